// File: rtl/fa_bist_pkg.sv
// ---------------------------------------------------------------------------
// fa_bist_pkg
// Shared types and constants for the full-adder BIST controller.
//   state_e        : controller FSM states
//   NUM_VECTORS    : number of exhaustive input combinations of a full adder
//   VEC_W          : width of a vector index {a,b,cin}
//   ERR_W          : width of the mismatch counter (holds 0..NUM_VECTORS)
//   SETTLE_CNT_W   : width of the settle down-counter (SETTLE_CYCLES 0..15)
// ---------------------------------------------------------------------------
package fa_bist_pkg;

    localparam int NUM_VECTORS  = 8;
    localparam int VEC_W        = 3;
    localparam int ERR_W        = 4;
    localparam int SETTLE_CNT_W = 4;

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        DRIVE  = 3'd1,
        SETTLE = 3'd2,
        CHECK  = 3'd3,
        DONE   = 3'd4
    } state_e;

    // True when idx addresses the final vector of a sweep.
    function automatic logic is_last_vec(input logic [VEC_W-1:0] idx);
        return idx == VEC_W'(NUM_VECTORS - 1);
    endfunction

endpackage

// File: rtl/full_adder.sv
// ---------------------------------------------------------------------------
// full_adder
// Single-bit combinational full adder; used by the BIST controller as the
// golden reference for the external adder under test.
//   a, b, cin  : operand bits and carry in
//   sum        : a ^ b ^ cin
//   carry_out  : majority(a, b, cin)
// ---------------------------------------------------------------------------
module full_adder (
    input  logic a,
    input  logic b,
    input  logic cin,
    output logic sum,
    output logic carry_out
);

    assign sum       = a ^ b ^ cin;
    assign carry_out = (a & b) | (a & cin) | (b & cin);

endmodule

// File: rtl/fa_bist_ctrl.sv
// ---------------------------------------------------------------------------
// fa_bist_ctrl
// Exhaustive built-in self test for an external single-bit full adder.
// On an accepted start the controller walks the eight input vectors
// {a,b,cin} = 0..7. Each vector is driven for one cycle, allowed to settle
// for SETTLE_CYCLES cycles, then the adder's response is compared against a
// golden full_adder instance. Mismatches are counted and the first failing
// vector index is captured.
//
// Parameters
//   SETTLE_CYCLES  : idle cycles between driving and sampling (0..15)
// Ports
//   clk            : clock, all state on the rising edge
//   reset          : synchronous active-high reset
//   start          : one-cycle sweep request (honoured in IDLE/DONE only)
//   dut_sum        : sum response from the adder under test
//   dut_carry_out  : carry response from the adder under test
//   dut_a/b/cin    : registered stimulus to the adder under test
//   busy           : sweep in progress
//   done           : sweep finished (level, until next start or reset)
//   pass           : no mismatches in the finished sweep (valid with done)
//   err_count      : mismatching vectors in the current sweep
//   fail_valid     : at least one mismatch recorded in the current sweep
//   first_fail_vec : index of the first mismatching vector
// ---------------------------------------------------------------------------
module fa_bist_ctrl
    import fa_bist_pkg::*;
#(
    parameter int SETTLE_CYCLES = 2
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic             dut_sum,
    input  logic             dut_carry_out,
    output logic             dut_a,
    output logic             dut_b,
    output logic             dut_cin,
    output logic             busy,
    output logic             done,
    output logic             pass,
    output logic [ERR_W-1:0] err_count,
    output logic             fail_valid,
    output logic [VEC_W-1:0] first_fail_vec
);

    // The counter is loaded in DRIVE and SETTLE exits when it reads zero,
    // so loading SETTLE_CYCLES-1 yields exactly SETTLE_CYCLES settle cycles.
    localparam logic [SETTLE_CNT_W-1:0] SETTLE_LOAD =
        (SETTLE_CYCLES > 0) ? SETTLE_CNT_W'(SETTLE_CYCLES - 1) : '0;

    state_e                  state_q, state_d;
    logic [VEC_W-1:0]        vec_idx_q, vec_idx_d;
    logic [VEC_W-1:0]        stim_q, stim_d;
    logic [SETTLE_CNT_W-1:0] settle_cnt_q, settle_cnt_d;
    logic [ERR_W-1:0]        err_count_q, err_count_d;
    logic                    fail_valid_q, fail_valid_d;
    logic [VEC_W-1:0]        first_fail_q, first_fail_d;
    logic                    pass_q, pass_d;

    logic                    start_accept;
    logic                    gold_sum;
    logic                    gold_carry;
    logic                    mismatch;

    // Golden reference is fed from vec_idx, which equals the registered
    // stimulus throughout CHECK, so both adders see the same operands.
    full_adder u_golden (
        .a         (vec_idx_q[2]),
        .b         (vec_idx_q[1]),
        .cin       (vec_idx_q[0]),
        .sum       (gold_sum),
        .carry_out (gold_carry)
    );

    assign start_accept = start && ((state_q == IDLE) || (state_q == DONE));
    assign mismatch     = (dut_sum != gold_sum) || (dut_carry_out != gold_carry);

    // -----------------------------------------------------------------------
    // State register
    // -----------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // -----------------------------------------------------------------------
    // Next-state logic
    // -----------------------------------------------------------------------
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            IDLE, DONE: begin
                if (start) begin
                    state_d = DRIVE;
                end
            end
            DRIVE: begin
                state_d = (SETTLE_CYCLES == 0) ? CHECK : SETTLE;
            end
            SETTLE: begin
                if (settle_cnt_q == '0) begin
                    state_d = CHECK;
                end
            end
            CHECK: begin
                state_d = is_last_vec(vec_idx_q) ? DONE : DRIVE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // -----------------------------------------------------------------------
    // Datapath next-state: stimulus, settle counter, result bookkeeping
    // -----------------------------------------------------------------------
    always_comb begin
        vec_idx_d    = vec_idx_q;
        stim_d       = stim_q;
        settle_cnt_d = settle_cnt_q;
        err_count_d  = err_count_q;
        fail_valid_d = fail_valid_q;
        first_fail_d = first_fail_q;
        pass_d       = pass_q;

        unique case (state_q)
            IDLE, DONE: begin
                // Stimulus is deliberately left alone so the adder keeps its
                // last operands while the controller is parked.
                if (start_accept) begin
                    vec_idx_d    = '0;
                    err_count_d  = '0;
                    fail_valid_d = 1'b0;
                    first_fail_d = '0;
                    pass_d       = 1'b0;
                end
            end
            DRIVE: begin
                stim_d       = vec_idx_q;
                settle_cnt_d = SETTLE_LOAD;
            end
            SETTLE: begin
                if (settle_cnt_q != '0) begin
                    settle_cnt_d = settle_cnt_q - SETTLE_CNT_W'(1);
                end
            end
            CHECK: begin
                // Eight vectors fit in ERR_W bits, so no saturation needed.
                if (mismatch) begin
                    err_count_d = err_count_q + ERR_W'(1);
                    if (!fail_valid_q) begin
                        fail_valid_d = 1'b1;
                        first_fail_d = vec_idx_q;
                    end
                end
                if (is_last_vec(vec_idx_q)) begin
                    // Verdict includes the result of this final vector.
                    pass_d = (err_count_d == '0);
                end else begin
                    vec_idx_d = vec_idx_q + VEC_W'(1);
                end
            end
            default: begin
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            vec_idx_q    <= '0;
            stim_q       <= '0;
            settle_cnt_q <= '0;
            err_count_q  <= '0;
            fail_valid_q <= 1'b0;
            first_fail_q <= '0;
            pass_q       <= 1'b0;
        end else begin
            vec_idx_q    <= vec_idx_d;
            stim_q       <= stim_d;
            settle_cnt_q <= settle_cnt_d;
            err_count_q  <= err_count_d;
            fail_valid_q <= fail_valid_d;
            first_fail_q <= first_fail_d;
            pass_q       <= pass_d;
        end
    end

    // -----------------------------------------------------------------------
    // Output logic
    // -----------------------------------------------------------------------
    always_comb begin
        busy = (state_q == DRIVE) || (state_q == SETTLE) || (state_q == CHECK);
        done = (state_q == DONE);
    end

    assign dut_a          = stim_q[2];
    assign dut_b          = stim_q[1];
    assign dut_cin        = stim_q[0];
    assign pass           = pass_q;
    assign err_count      = err_count_q;
    assign fail_valid     = fail_valid_q;
    assign first_fail_vec = first_fail_q;

endmodule

// File: tb/tb_fa_bist_ctrl.sv
// ---------------------------------------------------------------------------
// tb_fa_bist_ctrl
// Bench for fa_bist_ctrl. Two controller instances (SETTLE_CYCLES = 2 and 0)
// each drive a modelled external full adder whose sum/carry can be flipped
// per vector through fault masks. Directed sweeps come from a table; random
// fault masks are scored against a reference computed from the masks alone.
// ---------------------------------------------------------------------------
module tb_fa_bist_ctrl;

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic       start = 1'b0;
    logic       sel = 1'b0;          // 0: SETTLE_CYCLES=2 instance, 1: =0
    logic [7:0] sum_m = 8'h00;       // per-vector sum flip mask
    logic [7:0] carry_m = 8'h00;     // per-vector carry flip mask

    int vectors = 0;
    int miscompares = 0;

    always #5 clk = ~clk;

    // Instance with SETTLE_CYCLES = 2
    logic       s2_start, s2_a, s2_b, s2_cin, s2_sum, s2_carry;
    logic       s2_busy, s2_done, s2_pass, s2_fv;
    logic [3:0] s2_err;
    logic [2:0] s2_first, s2_idx;

    // Instance with SETTLE_CYCLES = 0
    logic       s0_start, s0_a, s0_b, s0_cin, s0_sum, s0_carry;
    logic       s0_busy, s0_done, s0_pass, s0_fv;
    logic [3:0] s0_err;
    logic [2:0] s0_first, s0_idx;

    assign s2_start = start & ~sel;
    assign s0_start = start & sel;

    // External adders under test with injectable faults
    assign s2_idx   = {s2_a, s2_b, s2_cin};
    assign s2_sum   = (s2_a ^ s2_b ^ s2_cin) ^ sum_m[s2_idx];
    assign s2_carry = ((s2_a & s2_b) | (s2_a & s2_cin) | (s2_b & s2_cin)) ^ carry_m[s2_idx];
    assign s0_idx   = {s0_a, s0_b, s0_cin};
    assign s0_sum   = (s0_a ^ s0_b ^ s0_cin) ^ sum_m[s0_idx];
    assign s0_carry = ((s0_a & s0_b) | (s0_a & s0_cin) | (s0_b & s0_cin)) ^ carry_m[s0_idx];

    fa_bist_ctrl #(.SETTLE_CYCLES(2)) u_dut2 (
        .clk(clk), .reset(reset), .start(s2_start),
        .dut_sum(s2_sum), .dut_carry_out(s2_carry),
        .dut_a(s2_a), .dut_b(s2_b), .dut_cin(s2_cin),
        .busy(s2_busy), .done(s2_done), .pass(s2_pass),
        .err_count(s2_err), .fail_valid(s2_fv), .first_fail_vec(s2_first)
    );

    fa_bist_ctrl #(.SETTLE_CYCLES(0)) u_dut0 (
        .clk(clk), .reset(reset), .start(s0_start),
        .dut_sum(s0_sum), .dut_carry_out(s0_carry),
        .dut_a(s0_a), .dut_b(s0_b), .dut_cin(s0_cin),
        .busy(s0_busy), .done(s0_done), .pass(s0_pass),
        .err_count(s0_err), .fail_valid(s0_fv), .first_fail_vec(s0_first)
    );

    // Observation of the currently selected instance
    logic       o_busy, o_done, o_pass, o_fv;
    logic [3:0] o_err;
    logic [2:0] o_first, o_stim;
    assign o_busy  = sel ? s0_busy  : s2_busy;
    assign o_done  = sel ? s0_done  : s2_done;
    assign o_pass  = sel ? s0_pass  : s2_pass;
    assign o_fv    = sel ? s0_fv    : s2_fv;
    assign o_err   = sel ? s0_err   : s2_err;
    assign o_first = sel ? s0_first : s2_first;
    assign o_stim  = sel ? s0_idx   : s2_idx;

    typedef struct {
        logic       use_s0;
        logic [7:0] sm;
        logic [7:0] cm;
        int         exp_err;
        int         exp_first;
        int         exp_pass;
        int         exp_fv;
        int         repulse;   // cycle after acceptance to re-pulse start, 0 = none
    } vec_t;

    vec_t tbl[8];

    task automatic check(input string name, input int act, input int exp);
        vectors++;
        if (act != exp) begin
            miscompares++;
            $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Runs one sweep on the selected instance and checks timing and results.
    task automatic run_sweep(input logic use_s0, input logic [7:0] sm, input logic [7:0] cm,
                             input int exp_err, input int exp_first, input int exp_pass,
                             input int exp_fv, input int repulse);
        int per;
        int n;
        bit got;
        sel     = use_s0;
        sum_m   = sm;
        carry_m = cm;
        per     = use_s0 ? 2 : 4;
        @(posedge clk); #1;
        start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        check("accept_busy", int'(o_busy), 1);
        check("accept_done_clr", int'(o_done), 0);
        check("accept_err_clr", int'(o_err), 0);
        check("accept_fv_clr", int'(o_fv), 0);
        n   = 0;
        got = 1'b0;
        while (!got && n < 200) begin
            @(posedge clk); #1;
            n++;
            start = (n == repulse);
            if (((n - 1) % per == 0) && ((n - 1) / per < 8))
                check("stim_step", int'(o_stim), (n - 1) / per);
            if (o_done) got = 1'b1;
        end
        start = 1'b0;
        check("done_latency", got ? n : -1, 8 * per);
        check("err_count", int'(o_err), exp_err);
        check("pass", int'(o_pass), exp_pass);
        check("fail_valid", int'(o_fv), exp_fv);
        if (exp_fv != 0) check("first_fail_vec", int'(o_first), exp_first);
        check("busy_at_done", int'(o_busy), 0);
        check("stim_hold", int'(o_stim), 7);
        repeat (3) @(posedge clk);
        #1;
        check("done_level", int'(o_done), 1);
        check("pass_hold", int'(o_pass), exp_pass);
    endtask

    initial begin
        int k;
        bit got;
        logic [7:0] rs, rc, any;
        int r_err, r_first;

        tbl[0] = '{1'b0, 8'h00, 8'h00, 0, 0, 1, 0, 0};   // golden, settle 2
        tbl[1] = '{1'b0, 8'h00, 8'hE8, 4, 3, 0, 1, 0};   // carry stuck-at-0
        tbl[2] = '{1'b0, 8'hFF, 8'h00, 8, 0, 0, 1, 0};   // sum inverted
        tbl[3] = '{1'b0, 8'h20, 8'h00, 1, 5, 0, 1, 0};   // single sum fault on vector 5
        tbl[4] = '{1'b1, 8'h00, 8'h00, 0, 0, 1, 0, 0};   // golden, settle 0
        tbl[5] = '{1'b1, 8'h00, 8'hE8, 4, 3, 0, 1, 0};   // carry stuck-at-0, settle 0
        tbl[6] = '{1'b0, 8'h00, 8'h00, 0, 0, 1, 0, 10};  // start re-pulsed mid-sweep
        tbl[7] = '{1'b0, 8'h80, 8'h80, 1, 7, 0, 1, 0};   // both outputs wrong on last vector

        // Reset, with start held high to show reset wins
        start = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        check("rst_busy", int'(s2_busy | s0_busy), 0);
        check("rst_done", int'(s2_done | s0_done), 0);
        check("rst_pass", int'(s2_pass | s0_pass), 0);
        check("rst_err", int'(s2_err) + int'(s0_err), 0);
        check("rst_fv", int'(s2_fv | s0_fv), 0);
        check("rst_first", int'(s2_first) + int'(s0_first), 0);
        check("rst_stim", int'(s2_idx) + int'(s0_idx), 0);
        start = 1'b0;
        reset = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        check("idle_no_start", int'(s2_busy | s2_done), 0);

        // Directed table
        for (int i = 0; i < 8; i++)
            run_sweep(tbl[i].use_s0, tbl[i].sm, tbl[i].cm, tbl[i].exp_err,
                      tbl[i].exp_first, tbl[i].exp_pass, tbl[i].exp_fv, tbl[i].repulse);

        // Reset at vector 4 aborts the sweep permanently
        sel = 1'b0; sum_m = 8'h00; carry_m = 8'h00;
        @(posedge clk); #1;
        start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        got = 1'b0;
        k = 0;
        while (!got && k < 100) begin
            @(posedge clk); #1;
            k++;
            if (o_stim == 3'd4) got = 1'b1;
        end
        check("reach_vec4", int'(got), 1);
        reset = 1'b1;
        @(posedge clk); #1;
        reset = 1'b0;
        check("abort_busy", int'(o_busy), 0);
        check("abort_done", int'(o_done), 0);
        check("abort_pass", int'(o_pass), 0);
        check("abort_err", int'(o_err), 0);
        check("abort_fv", int'(o_fv), 0);
        check("abort_first", int'(o_first), 0);
        check("abort_stim", int'(o_stim), 0);
        repeat (40) @(posedge clk);
        #1;
        check("no_resume", int'(o_busy | o_done), 0);
        run_sweep(1'b0, 8'h00, 8'h00, 0, 0, 1, 0, 0);

        // Random fault masks scored by counting faulty vectors
        for (int r = 0; r < 12; r++) begin
            rs = 8'($urandom) & 8'($urandom);
            rc = 8'($urandom) & 8'($urandom);
            if ($urandom_range(0, 3) == 0) begin
                rs = 8'h00;
                rc = 8'h00;
            end
            any     = rs | rc;
            r_err   = $countones(any);
            r_first = 0;
            for (int b = 7; b >= 0; b--)
                if (any[b]) r_first = b;
            run_sweep(1'($urandom_range(0, 1)), rs, rc, r_err, r_first,
                      (r_err == 0) ? 1 : 0, (r_err != 0) ? 1 : 0, 0);
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/fa_bist_ctrl.md
FA_BIST_CTRL -- requirements
Module: fa_bist_ctrl

Interface
REQ-001 Parameter SETTLE_CYCLES, default 2: idle cycles between applying a vector and sampling the DUT response; legal range 0..15.
REQ-002 clk  input  1  single clock; all state updates on the rising edge.
REQ-003 reset  input  1  synchronous, active-high reset.
REQ-004 start  input  1  one-cycle request to begin an exhaustive sweep.
REQ-005 dut_sum  input  1  sum response from the external full adder under test.
REQ-006 dut_carry_out  input  1  carry response from the external full adder under test.
REQ-007 dut_a, dut_b, dut_cin  output  1 each  registered stimulus to the DUT.
REQ-008 busy  output  1  high from sweep acceptance until DONE is entered.
REQ-009 done  output  1  level; high in DONE until the next accepted start or reset.
REQ-010 pass  output  1  valid while done=1; high iff err_count==0.
REQ-011 err_count  output  4  number of mismatching vectors in the current sweep, 0..8.
REQ-012 fail_valid  output  1  high once any mismatch is recorded in the current sweep.
REQ-013 first_fail_vec  output  3  index {a,b,cin} of the first mismatching vector; meaningful only when fail_valid=1.

Function
REQ-014 The FSM SHALL have states IDLE, DRIVE, SETTLE, CHECK, DONE.
REQ-015 In IDLE or DONE with start=1 -> DRIVE; vec_idx, err_count, fail_valid, first_fail_vec, done and pass cleared on that edge.
REQ-016 start SHALL be ignored in DRIVE, SETTLE and CHECK.
REQ-017 DRIVE (1 cycle): {dut_a,dut_b,dut_cin} <= vec_idx; -> SETTLE, or -> CHECK if SETTLE_CYCLES==0.
REQ-018 SETTLE: held for exactly SETTLE_CYCLES cycles by a down-counter, then -> CHECK.
REQ-019 CHECK (1 cycle): compare dut_sum against a^b^cin and dut_carry_out against majority(a,b,cin); on any mismatch, err_count+1, and if fail_valid==0 set fail_valid=1 and first_fail_vec=vec_idx.
REQ-020 From CHECK: vec_idx==7 -> DONE; otherwise vec_idx+1 -> DRIVE (no wrap in-sweep).
REQ-021 Each vector SHALL occupy 2+SETTLE_CYCLES cycles; done SHALL rise 8*(2+SETTLE_CYCLES) cycles after the edge on which start is accepted.
REQ-022 pass SHALL be updated on DONE entry and held until the next start or reset.
REQ-023 Stimulus outputs SHALL hold their last value in DONE and IDLE.
REQ-024 err_count SHALL never exceed 8; no saturation logic is needed.

Reset
REQ-025 reset=1 SHALL force IDLE from any state, overriding start, with vec_idx=0, dut_a=dut_b=dut_cin=0, busy=0, done=0, pass=0, err_count=0, fail_valid=0, first_fail_vec=0.
REQ-026 A sweep interrupted by reset SHALL NOT resume; a new start is required.

Structure
REQ-027 Package fa_bist_pkg SHALL hold the state enum, NUM_VECTORS=8, VEC_W=3 and ERR_W=4.
REQ-028 Expected values SHALL come from one instance of the existing full_adder module (golden model) driven by vec_idx bits.
REQ-029 No other sub-modules.

Verification
REQ-030 Golden full_adder as DUT, SETTLE_CYCLES=2, start pulse -> done at +32 cycles, pass=1, err_count=0, fail_valid=0.
REQ-031 DUT carry_out stuck-at-0 -> err_count=4 (vectors 3,5,6,7), first_fail_vec=3, pass=0.
REQ-032 DUT sum inverted -> err_count=8, first_fail_vec=0, pass=0.
REQ-033 SETTLE_CYCLES=0 with golden DUT -> done at +16 cycles, pass=1; dut_a/b/cin step 000..111 every 2 cycles.
REQ-034 start re-pulsed mid-sweep -> ignored, done still at +32; reset at vector 4 -> all outputs at reset values next cycle; new start completes a full 8-vector sweep.
